// File: rtl/gray_rptr_sync.sv
// Read-domain pointer receiver for the async FIFO: syncs the Gray write pointer, keeps the read pointer, derives empty/fill/underflow.
// Latency: write pointer reaches empty/fill after 3 edges; reads update rd_addr/rptr_gray/empty/fill on the accepting edge.
// Backpressure: reads while empty are refused and flagged on rd_underflow. Optional Gray check: GRAY_PTR_CHECK_EN.
module gray_rptr_sync #(
    parameter int ADDR_WIDTH = 5,
    parameter int PTR_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PTR_WIDTH-1:0]  wptr_gray_in,
    input  logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [PTR_WIDTH-1:0]  rptr_gray,
    output logic                  empty,
    output logic [PTR_WIDTH-1:0]  fill,
    output logic                  rd_underflow,
    output logic                  gray_err
);

    function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] g);
        logic [PTR_WIDTH-1:0] b;
        b[PTR_WIDTH-1] = g[PTR_WIDTH-1];
        for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PTR_WIDTH-1:0] sync1_q;
    logic [PTR_WIDTH-1:0] sync2_q;
    logic [PTR_WIDTH-1:0] wbin_q;
    logic [PTR_WIDTH-1:0] rbin_q;
    logic [PTR_WIDTH-1:0] rbin_d;
    logic [PTR_WIDTH-1:0] rptr_gray_q;
    logic [PTR_WIDTH-1:0] rptr_gray_d;
    logic                 rd_underflow_q;
    logic                 rd_accept;

    // Two plain flops: nothing may sit between them or metastability can propagate.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            wbin_q  <= '0;
        end else begin
            sync1_q <= wptr_gray_in;
            sync2_q <= sync1_q;
            wbin_q  <= gray2bin(sync2_q);
        end
    end

    // rd_accept doubles as the RAM read enable; raw rd_en must never reach the RAM.
    always_comb begin
        empty       = (wbin_q == rbin_q);
        fill        = wbin_q - rbin_q;
        rd_accept   = rd_en & ~empty;
        rbin_d      = rd_accept ? (rbin_q + PTR_WIDTH'(1)) : rbin_q;
        rptr_gray_d = rbin_d ^ (rbin_d >> 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rbin_q         <= '0;
            rptr_gray_q    <= '0;
            rd_underflow_q <= 1'b0;
        end else begin
            rbin_q         <= rbin_d;
            rptr_gray_q    <= rptr_gray_d;
            rd_underflow_q <= rd_en & empty;
        end
    end

    assign rd_addr      = rbin_q[ADDR_WIDTH-1:0];
    assign rptr_gray    = rptr_gray_q;
    assign rd_underflow = rd_underflow_q;

`ifdef GRAY_PTR_CHECK_EN
    logic [PTR_WIDTH-1:0] wgray_q;
    logic [PTR_WIDTH-1:0] gray_diff;
    logic                 multi_bit;
    logic                 gray_err_q;

    // x & (x-1) is nonzero exactly when more than one bit of x is set.
    always_comb begin
        gray_diff = sync2_q ^ wgray_q;
        multi_bit = |(gray_diff & (gray_diff - PTR_WIDTH'(1)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wgray_q    <= '0;
            gray_err_q <= 1'b0;
        end else begin
            wgray_q <= sync2_q;
            if (multi_bit) begin
                gray_err_q <= 1'b1;
            end
        end
    end

    assign gray_err = gray_err_q;
`else
    assign gray_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_rptr_sync.sv
// Scoreboarded bench for gray_rptr_sync: stimulus pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_gray_rptr_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] wptr_gray_in;
    logic       rd_en;
    logic [4:0] rd_addr;
    logic [5:0] rptr_gray;
    logic       empty;
    logic [5:0] fill;
    logic       rd_underflow;
    logic       gray_err;

    gray_rptr_sync dut (
        .clk         (clk),
        .rst         (rst),
        .wptr_gray_in(wptr_gray_in),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rptr_gray   (rptr_gray),
        .empty       (empty),
        .fill        (fill),
        .rd_underflow(rd_underflow),
        .gray_err    (gray_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int rg;
        int emp;
        int fl;
        int uf;
        int err;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: pointers as plain integers, sync delay as a queue of sampled Gray words.
    int m_rbin;
    int m_wbin;
    int m_uf;
    int m_err;
    int m_lastg;
    int wq[$];
    int wcnt;

    function automatic int gray6(input int b);
        return (b ^ (b >> 1)) & 63;
    endfunction

    function automatic int ungray6(input int g);
        int b;
        b = 0;
        for (int s = 0; s < 6; s++) b = b ^ (g >> s);
        return b & 63;
    endfunction

    function automatic int popc(input int v);
        int c;
        c = 0;
        for (int i = 0; i < 6; i++) c += (v >> i) & 1;
        return c;
    endfunction

    task automatic model_edge(input logic r, input int g, input logic re);
        int   popped;
        int   emp_pre;
        exp_t e;
        if (r) begin
            m_rbin = 0; m_wbin = 0; m_uf = 0; m_err = 0; m_lastg = 0;
            wq = '{0, 0};
        end else begin
            emp_pre = (m_wbin == m_rbin);
            m_uf    = (re && emp_pre) ? 1 : 0;
            if (re && !emp_pre) m_rbin = (m_rbin + 1) % 64;
            wq.push_back(g);
            popped = wq.pop_front();
`ifdef GRAY_PTR_CHECK_EN
            if (popc(popped ^ m_lastg) > 1) m_err = 1;
`endif
            m_lastg = popped;
            m_wbin  = ungray6(popped);
        end
        e.addr = m_rbin % 32;
        e.rg   = gray6(m_rbin);
        e.emp  = (m_wbin == m_rbin) ? 1 : 0;
        e.fl   = (m_wbin - m_rbin + 64) % 64;
        e.uf   = m_uf;
        e.err  = m_err;
        expq.push_back(e);
    endtask

    // One clock: drive inputs, let the edge happen, record what the model says the DUT now shows.
    task automatic cyc(input logic r, input int g, input logic re);
        rst          = r;
        wptr_gray_in = 6'(g);
        rd_en        = re;
        @(posedge clk);
        model_edge(r, g, re);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("rd_addr",      int'(rd_addr),      e.addr);
                chk("rptr_gray",    int'(rptr_gray),    e.rg);
                chk("empty",        int'(empty),        e.emp);
                chk("fill",         int'(fill),         e.fl);
                chk("rd_underflow", int'(rd_underflow), e.uf);
                chk("gray_err",     int'(gray_err),     e.err);
            end
        end
    end

    initial begin
        rst = 1'b1; wptr_gray_in = '0; rd_en = 1'b0;
        m_rbin = 0; m_wbin = 0; m_uf = 0; m_err = 0; m_lastg = 0; wq = '{0, 0};

        // Reset held with a nonzero pointer, then release: fill must reach 2 on the third edge.
        repeat (2) cyc(1'b1, 6'b000011, 1'b0);
        repeat (4) cyc(1'b0, 6'b000011, 1'b0);

        // Write visibility then drain with one underflowing read.
        repeat (2) cyc(1'b1, 0, 1'b0);
        cyc(1'b0, 6'b000000, 1'b0);
        cyc(1'b0, 6'b000001, 1'b0);
        cyc(1'b0, 6'b000011, 1'b0);
        cyc(1'b0, 6'b000010, 1'b0);
        repeat (3) cyc(1'b0, 6'b000010, 1'b0);
        repeat (4) cyc(1'b0, 6'b000010, 1'b1);
        repeat (2) cyc(1'b0, 6'b000010, 1'b0);

        // Full: write pointer walks to 32 with no reads.
        repeat (2) cyc(1'b1, 0, 1'b0);
        for (int w = 1; w <= 32; w++) cyc(1'b0, gray6(w), 1'b0);
        repeat (4) cyc(1'b0, gray6(32), 1'b0);
        repeat (3) cyc(1'b0, gray6(32), 1'b1);

        // Wrap-around: read pointer to 62, write pointer to 66 mod 64 = 2.
        repeat (2) cyc(1'b1, 0, 1'b0);
        wcnt = 0;
        for (int i = 0; i < 400 && m_rbin != 62; i++) begin
            if (wcnt < 62 && (wcnt - m_rbin) < 32) wcnt++;
            cyc(1'b0, gray6(wcnt), 1'b1);
        end
        for (int w = 63; w <= 66; w++) cyc(1'b0, gray6(w % 64), 1'b0);
        repeat (4) cyc(1'b0, gray6(2), 1'b0);
        repeat (2) cyc(1'b0, gray6(2), 1'b1);
        repeat (2) cyc(1'b0, gray6(2), 1'b0);

        // Illegal two-bit Gray step; flag must stick until the next reset.
        repeat (2) cyc(1'b1, 0, 1'b0);
        cyc(1'b0, 6'b000000, 1'b0);
        repeat (6) cyc(1'b0, 6'b000011, 1'b0);
        repeat (2) cyc(1'b1, 6'b000011, 1'b0);
        repeat (2) cyc(1'b0, 6'b000011, 1'b0);

        // Randomized traffic with a legal producer that never overfills.
        repeat (2) cyc(1'b1, 0, 1'b0);
        wcnt = 0;
        for (int seg = 0; seg < 6; seg++) begin
            int rd_pct;
            int wr_pct;
            rd_pct = $urandom_range(5, 95);
            wr_pct = $urandom_range(5, 95);
            for (int i = 0; i < 120; i++) begin
                if ($urandom_range(0, 99) < wr_pct && ((wcnt - m_rbin) & 63) < 32)
                    wcnt = (wcnt + 1) & 63;
                cyc(1'b0, gray6(wcnt), 1'($urandom_range(0, 99) < rd_pct));
            end
        end
        repeat (4) cyc(1'b0, gray6(wcnt), 1'b1);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gray_rptr_sync.md
# gray_rptr_sync

Read-domain pointer receiver for the async FIFO. Takes the write pointer that arrives in Gray code from the write clock domain and passes it through a 2-flop synchronizer. It then converts the pointer back to binary and keeps the local binary/Gray read pointer. From these it derives `empty`, the fill level, the read address and an underflow indication. It sits beside the FIFO RAM read port and is the Gray→binary counterpart of the write side's binary→Gray encoding.

## Interface
- `ADDR_WIDTH`, default 5: RAM address bits; FIFO depth = 2^ADDR_WIDTH (32).
- `PTR_WIDTH`, default ADDR_WIDTH+1 (6): pointer width, address bits plus one wrap bit.
- `clk`  in  1  read-domain clock. One clock; everything is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wptr_gray_in`  in  PTR_WIDTH  write pointer in Gray code, asynchronous to `clk`.
- `rd_en`  in  1  read request for the current cycle.
- `rd_addr`  out  ADDR_WIDTH  RAM read address = low ADDR_WIDTH bits of the binary read pointer.
- `rptr_gray`  out  PTR_WIDTH  registered Gray read pointer, sent to the write domain.
- `empty`  out  1  FIFO empty, as seen from the read domain.
- `fill`  out  PTR_WIDTH  occupied entries, 0..2^ADDR_WIDTH.
- `rd_underflow`  out  1  one-cycle pulse: `rd_en` was asserted while `empty`=1.
- `gray_err`  out  1  sticky Gray-sequence violation flag (see Configuration).

## Operation
- **Synchronizer:** `sync1 <= wptr_gray_in; sync2 <= sync1`. No logic between the two flops.
- **Decode stage:** `wgray_q <= sync2`; `wbin_q <= gray2bin(sync2)`, where `bin[MSB]=g[MSB]` and `bin[i]=bin[i+1]^g[i]`.
- **Read pointer:** `rbin` is a PTR_WIDTH binary counter.
  - A read is accepted when `rd_en && !empty`; then `rbin <= rbin+1`, wrapping 2^PTR_WIDTH−1 → 0.
  - `rptr_gray <= next_rbin ^ (next_rbin >> 1)`, registered on the same edge as `rbin`.
- **Status:**
  - `empty = (wbin_q == rbin)`, combinational from registers.
  - `fill = wbin_q − rbin` modulo 2^PTR_WIDTH. A full FIFO gives `fill` = 2^ADDR_WIDTH (6'b100000).
- **Underflow:**
  - `rd_underflow <= rd_en && empty`.
  - `rbin` does not move on an underflow.
  - The FIFO RAM read enable is the accepted-read term, not raw `rd_en`.
- **Simultaneous events:** a new `wbin_q` and an accepted read on the same edge both take effect. Next cycle, `fill` = new `wbin_q` − new `rbin`.
- **Reset:**
  - Registers cleared: `sync1`, `sync2`, `wgray_q`, `wbin_q`, `rbin`, `rptr_gray`, `rd_underflow`, `gray_err`.
  - Resulting outputs: `rd_addr`=0, `rptr_gray`=0, `empty`=1, `fill`=0, `rd_underflow`=0, `gray_err`=0.
  - Reset mid-operation discards all in-flight synchronizer contents. Both domains must be reset together.

## Timing
- `wptr_gray_in` held stable before edge N is reflected in `wbin_q`, and therefore in `empty`/`fill`, after edge N+2, i.e. 3-cycle latency.
- Read pointer: accepted read at edge N gives updated `rd_addr`, `rptr_gray`, `empty` and `fill` after edge N. That is 0 cycles of extra latency beyond the edge.
- `rd_underflow` is high for exactly the cycle following the offending edge.
- `empty` can be pessimistic (stale write pointer) but never optimistic.
- Back-to-back reads at one per cycle are supported until `empty`.

## Configuration
- Macro: `GRAY_PTR_CHECK_EN`.
- **Defined:** each cycle, compare `sync2` with `wgray_q`.
  - If more than one bit differs (popcount of XOR > 1), set `gray_err` <= 1.
  - `gray_err` is sticky until `rst`.
  - The check does not alter the pointer datapath.
- **Undefined:** the check logic is removed and `gray_err` is tied to 0.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles with `wptr_gray_in`=6'b000011.
  - Required: `empty`=1, `fill`=0, `rptr_gray`=0, `rd_addr`=0 throughout reset.
  - Release `rst` → `fill`=2 exactly 3 cycles later.
- **Write visibility:** step `wptr_gray_in` through 000000, 000001, 000011, 000010, one per cycle.
  - Required: `fill`=3 and `empty`=0 three cycles after the last step, with no intermediate value above 3.
- **Drain and underflow:** with `fill`=3, assert `rd_en` for 4 cycles.
  - Required: `rd_addr` 0→1→2→3; `rptr_gray` 000001, 000011, 000010.
  - `empty`=1 after the third read; the fourth read gives `rd_underflow`=1 for one cycle; `rd_addr` stays 3.
- **Full:** hold `wptr_gray_in`=gray(32)=6'b110000 with `rbin`=0.
  - Required: `fill`=32, `empty`=0.
- **Wrap-around:** drive the write pointer to gray(2)=000011 and the read pointer to 62.
  - Required: `fill`=4.
  - Read 2 → `rbin`=0, `rptr_gray`=000000, `rd_addr`=0, `fill`=2.
- **Gray check:** step `wptr_gray_in` 000000→000011 in one cycle.
  - With `GRAY_PTR_CHECK_EN`: `gray_err`=1 three cycles later, and it stays 1 until `rst`.
  - Without the macro: `gray_err`=0.
